// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite master-side bundle for axi4_lite_arbiter; signal names mirror the
// legacy pAXI4_* port names so pAXI4.<sig> reads like the original flat port.
interface axi4_lite_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int RESP_W = 2
) ();
  logic              ar_ready;
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_bits_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_bits_data;
  logic [RESP_W-1:0] r_bits_resp;
  logic              r_ready;
  logic              aw_ready;
  logic              aw_valid;
  logic [ADDR_W-1:0] aw_bits_addr;
  logic              w_ready;
  logic              w_valid;
  logic [DATA_W-1:0] w_bits_data;
  logic [MASK_W-1:0] w_bits_strb;
  logic              b_valid;
  logic [RESP_W-1:0] b_bits_resp;
  logic              b_ready;

  modport master (
    input  ar_ready, r_valid, r_bits_data, r_bits_resp, aw_ready, w_ready, b_valid, b_bits_resp,
    output ar_valid, ar_bits_addr, r_ready, aw_valid, aw_bits_addr, w_valid, w_bits_data,
           w_bits_strb, b_ready
  );

  modport slave (
    output ar_ready, r_valid, r_bits_data, r_bits_resp, aw_ready, w_ready, b_valid, b_bits_resp,
    input  ar_valid, ar_bits_addr, r_ready, aw_valid, aw_bits_addr, w_valid, w_bits_data,
           w_bits_strb, b_ready
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter onto one AXI4-Lite master,
// one transaction in flight. AXI_ARB_RR_EN selects round-robin, else LSU has fixed priority.
module axi4_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int RESP_W = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iIfuReq,
  input  logic [ADDR_W-1:0] iIfuAddr,
  output logic              oIfuGnt,
  output logic              oIfuRspValid,
  output logic [DATA_W-1:0] oIfuRspData,
  output logic [RESP_W-1:0] oIfuRspResp,
  input  logic              iLsuReq,
  input  logic              iLsuWe,
  input  logic [ADDR_W-1:0] iLsuAddr,
  input  logic [DATA_W-1:0] iLsuWData,
  input  logic [MASK_W-1:0] iLsuWMask,
  output logic              oLsuGnt,
  output logic              oLsuRspValid,
  output logic [DATA_W-1:0] oLsuRspData,
  output logic [RESP_W-1:0] oLsuRspResp,
  axi4_lite_arbiter_if.master pAXI4
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t            r_state, w_next;
  logic              r_owner_lsu, r_aw_done, r_w_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_ifu_data, r_lsu_data;
  logic [MASK_W-1:0] r_wmask;
  logic [RESP_W-1:0] r_ifu_resp, r_lsu_resp;

  logic w_ifu_win, w_lsu_win, w_grant;
  logic w_ar_valid, w_r_ready, w_aw_valid, w_w_valid, w_b_ready;
  logic w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

`ifdef AXI_ARB_RR_EN
  logic r_last_lsu;

  always_comb begin
    w_lsu_win = iLsuReq && (!iIfuReq || !r_last_lsu);
    w_ifu_win = iIfuReq && !w_lsu_win;
  end

  always_ff @(posedge iClock) begin
    if (iReset)       r_last_lsu <= 1'b0;
    else if (w_grant) r_last_lsu <= w_lsu_win;
  end
`else
  always_comb begin
    w_lsu_win = iLsuReq;
    w_ifu_win = iIfuReq && !iLsuReq;
  end
`endif

  // Grant and response pulses are masked during reset so an aborted transfer stays silent.
  assign w_grant      = (r_state == IDLE) && !iReset && (w_ifu_win || w_lsu_win);
  assign oIfuGnt      = (r_state == IDLE) && !iReset && w_ifu_win;
  assign oLsuGnt      = (r_state == IDLE) && !iReset && w_lsu_win;
  assign oIfuRspValid = (r_state == RSP) && !iReset && !r_owner_lsu;
  assign oLsuRspValid = (r_state == RSP) && !iReset && r_owner_lsu;

  assign w_r_hs  = (r_state == RD_DATA) && pAXI4.r_valid;
  assign w_aw_hs = (r_state == WR_REQ) && !r_aw_done && pAXI4.aw_ready;
  assign w_w_hs  = (r_state == WR_REQ) && !r_w_done && pAXI4.w_ready;
  assign w_b_hs  = (r_state == WR_RESP) && pAXI4.b_valid;

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ar_valid = 1'b0;
    w_r_ready  = 1'b0;
    w_aw_valid = 1'b0;
    w_w_valid  = 1'b0;
    w_b_ready  = 1'b0;
    case (r_state)
      IDLE:    if (w_grant) w_next = (w_lsu_win && iLsuWe) ? WR_REQ : RD_ADDR;
      RD_ADDR: begin
        w_ar_valid = 1'b1;
        if (pAXI4.ar_ready) w_next = RD_DATA;
      end
      RD_DATA: begin
        w_r_ready = 1'b1;
        if (w_r_hs) w_next = RSP;
      end
      WR_REQ: begin
        w_aw_valid = !r_aw_done;
        w_w_valid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        w_b_ready = 1'b1;
        if (w_b_hs) w_next = RSP;
      end
      RSP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_owner_lsu <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_ifu_data  <= '0;
      r_ifu_resp  <= '0;
      r_lsu_data  <= '0;
      r_lsu_resp  <= '0;
    end else begin
      if (w_grant) begin
        r_owner_lsu <= w_lsu_win;
        r_addr      <= w_lsu_win ? iLsuAddr : iIfuAddr;
        r_wdata     <= w_lsu_win ? iLsuWData : '0;
        r_wmask     <= w_lsu_win ? iLsuWMask : '0;
        r_aw_done   <= 1'b0;
        r_w_done    <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_r_hs) begin
        if (r_owner_lsu) begin
          r_lsu_data <= pAXI4.r_bits_data;
          r_lsu_resp <= pAXI4.r_bits_resp;
        end else begin
          r_ifu_data <= pAXI4.r_bits_data;
          r_ifu_resp <= pAXI4.r_bits_resp;
        end
      end
      if (w_b_hs) begin
        r_lsu_data <= '0;
        r_lsu_resp <= pAXI4.b_bits_resp;
      end
    end
  end

  assign oIfuRspData = r_ifu_data;
  assign oIfuRspResp = r_ifu_resp;
  assign oLsuRspData = r_lsu_data;
  assign oLsuRspResp = r_lsu_resp;

  assign pAXI4.ar_valid     = w_ar_valid;
  assign pAXI4.ar_bits_addr = r_addr;
  assign pAXI4.r_ready      = w_r_ready;
  assign pAXI4.aw_valid     = w_aw_valid;
  assign pAXI4.aw_bits_addr = r_addr;
  assign pAXI4.w_valid      = w_w_valid;
  assign pAXI4.w_bits_data  = r_wdata;
  assign pAXI4.w_bits_strb  = r_wmask;
  assign pAXI4.b_ready      = w_b_ready;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Self-checking bench for axi4_lite_arbiter: directed scenarios plus randomized
// transactions against a latency/arbitration model; honours AXI_ARB_RR_EN.
module tb_axi4_lite_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int RESP_W = 2;

  logic              iClock = 1'b0;
  logic              iReset;
  logic              iIfuReq, iLsuReq, iLsuWe;
  logic [ADDR_W-1:0] iIfuAddr, iLsuAddr;
  logic [DATA_W-1:0] iLsuWData;
  logic [MASK_W-1:0] iLsuWMask;
  logic              oIfuGnt, oIfuRspValid, oLsuGnt, oLsuRspValid;
  logic [DATA_W-1:0] oIfuRspData, oLsuRspData;
  logic [RESP_W-1:0] oIfuRspResp, oLsuRspResp;

  axi4_lite_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_W(RESP_W)) axi ();

  axi4_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_W(RESP_W)) dut (
    .iClock(iClock), .iReset(iReset),
    .iIfuReq(iIfuReq), .iIfuAddr(iIfuAddr), .oIfuGnt(oIfuGnt),
    .oIfuRspValid(oIfuRspValid), .oIfuRspData(oIfuRspData), .oIfuRspResp(oIfuRspResp),
    .iLsuReq(iLsuReq), .iLsuWe(iLsuWe), .iLsuAddr(iLsuAddr), .iLsuWData(iLsuWData),
    .iLsuWMask(iLsuWMask), .oLsuGnt(oLsuGnt),
    .oLsuRspValid(oLsuRspValid), .oLsuRspData(oLsuRspData), .oLsuRspResp(oLsuRspResp),
    .pAXI4(axi)
  );

  always #5 iClock = ~iClock;

  int n_pass = 0;
  int n_total = 0;

  // Slave configuration (written by tests) and observations (written by the slave).
  int                cfg_ar_d = 0, cfg_r_d = 0, cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0;
  logic [DATA_W-1:0] cfg_rdata = '0;
  logic [RESP_W-1:0] cfg_rresp = '0, cfg_bresp = '0;
  int                ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
  int                ar_hi = 0, aw_hi = 0, w_hi = 0;
  bit                ar_p = 0, aw_p = 0, w_p = 0, b_early = 0;
  logic [ADDR_W-1:0] cap_ar = '0, cap_aw = '0;
  logic [DATA_W-1:0] cap_w = '0;
  logic [MASK_W-1:0] cap_strb = '0;

  // Slave: each ready/valid rises after its configured number of cycles of the opposite side.
  initial begin
    axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_bits_data = '0; axi.r_bits_resp = '0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_bits_resp = '0;
    forever begin
      @(posedge iClock); #1;
      if (axi.ar_valid) begin if (!ar_p) ar_hi = 0; ar_hi++; end
      if (axi.aw_valid) begin if (!aw_p) begin aw_hi = 0; b_early = 0; end aw_hi++; end
      if (axi.w_valid)  begin if (!w_p) w_hi = 0; w_hi++; end
      ar_p = axi.ar_valid; aw_p = axi.aw_valid; w_p = axi.w_valid;
      if (axi.b_ready && (axi.aw_valid || axi.w_valid)) b_early = 1;

      axi.ar_ready = axi.ar_valid && (ar_c >= cfg_ar_d); ar_c = axi.ar_valid ? ar_c + 1 : 0;
      axi.aw_ready = axi.aw_valid && (aw_c >= cfg_aw_d); aw_c = axi.aw_valid ? aw_c + 1 : 0;
      axi.w_ready  = axi.w_valid  && (w_c  >= cfg_w_d);  w_c  = axi.w_valid  ? w_c + 1  : 0;
      axi.r_valid  = axi.r_ready  && (r_c  >= cfg_r_d);  r_c  = axi.r_ready  ? r_c + 1  : 0;
      axi.b_valid  = axi.b_ready  && (b_c  >= cfg_b_d);  b_c  = axi.b_ready  ? b_c + 1  : 0;
      axi.r_bits_data = axi.r_valid ? cfg_rdata : '0;
      axi.r_bits_resp = axi.r_valid ? cfg_rresp : '0;
      axi.b_bits_resp = axi.b_valid ? cfg_bresp : '0;

      if (axi.ar_valid && axi.ar_ready) cap_ar = axi.ar_bits_addr;
      if (axi.aw_valid && axi.aw_ready) cap_aw = axi.aw_bits_addr;
      if (axi.w_valid && axi.w_ready) begin cap_w = axi.w_bits_data; cap_strb = axi.w_bits_strb; end
    end
  end

  task automatic apply_reset(input int n);
    iReset = 1'b1;
    repeat (n) begin @(posedge iClock); #2; end
    iReset = 1'b0;
  endtask

  task automatic set_cfg(input int ar, input int r, input int aw, input int w, input int b);
    cfg_ar_d = ar; cfg_r_d = r; cfg_aw_d = aw; cfg_w_d = w; cfg_b_d = b;
  endtask

  // Driver only: presents requests in an IDLE cycle, runs to the response pulse, returns
  // one cycle after it. lat = cycles from grant to pulse, -1 if the pulse never came.
  task automatic do_txn(input logic ifu, input logic lsu, input logic we,
                        input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] la,
                        input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm,
                        input bit keep_loser,
                        output logic [1:0] gnt, output logic [1:0] gnt_after, output int lat,
                        output logic [1:0] pulse, output logic [1:0] pulse_after);
    iIfuReq = ifu; iIfuAddr = ia;
    iLsuReq = lsu; iLsuWe = we; iLsuAddr = la; iLsuWData = wd; iLsuWMask = wm;
    #1;
    gnt = {oIfuGnt, oLsuGnt};
    @(posedge iClock); #2;
    gnt_after = {oIfuGnt, oLsuGnt};
    if (gnt[1] || !keep_loser) iIfuReq = 1'b0;
    if (gnt[0] || !keep_loser) iLsuReq = 1'b0;
    lat = -1; pulse = 2'b00;
    for (int c = 1; c < 200; c++) begin
      if (oIfuRspValid || oLsuRspValid) begin
        lat = c; pulse = {oIfuRspValid, oLsuRspValid};
        break;
      end
      @(posedge iClock); #2;
    end
    @(posedge iClock); #2;
    pulse_after = {oIfuRspValid, oLsuRspValid};
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    iReset = 1'b1; iIfuReq = 1'b1; iLsuReq = 1'b1; iLsuWe = 1'b1;
    iIfuAddr = 32'h1234_5678; iLsuAddr = 32'h9ABC_DEF0; iLsuWData = 32'hFFFF_FFFF; iLsuWMask = 4'hF;
    repeat (3) begin @(posedge iClock); #2; end
    ctl = {oIfuGnt, oLsuGnt, oIfuRspValid, oLsuRspValid, axi.ar_valid, axi.r_ready,
           axi.aw_valid, axi.w_valid, axi.b_ready};
    n_total++;
    if (ctl !== 9'h0) $display("FAIL reset_ctl: got %b expected 000000000", ctl); else n_pass++;
    n_total++;
    if ({oIfuRspData, oIfuRspResp, oLsuRspData, oLsuRspResp} !== '0)
      $display("FAIL reset_rsp: got %h %h %h %h expected zeros", oIfuRspData, oIfuRspResp,
               oLsuRspData, oLsuRspResp);
    else n_pass++;
    n_total++;
    if ({axi.ar_bits_addr, axi.aw_bits_addr, axi.w_bits_data, axi.w_bits_strb} !== '0)
      $display("FAIL reset_bus: got %h %h %h %h expected zeros", axi.ar_bits_addr,
               axi.aw_bits_addr, axi.w_bits_data, axi.w_bits_strb);
    else n_pass++;
    iIfuReq = 1'b0; iLsuReq = 1'b0;
    iReset = 1'b0;
    @(posedge iClock); #2;
  endtask

  task automatic test_ifu_read();
    logic [1:0] g, ga, p, pa; int lat;
    set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'h0000_0413; cfg_rresp = 2'b00;
    do_txn(1'b1, 1'b0, 1'b0, 32'h8000_0000, '0, '0, '0, 1'b0, g, ga, lat, p, pa);
    n_total++; if (g !== 2'b10) $display("FAIL ifu_gnt: got %b expected 10", g); else n_pass++;
    n_total++; if (ga !== 2'b00) $display("FAIL ifu_gnt_pulse: got %b expected 00", ga); else n_pass++;
    n_total++; if (ar_hi !== 1) $display("FAIL ifu_ar_cycles: got %0d expected 1", ar_hi); else n_pass++;
    n_total++; if (cap_ar !== 32'h8000_0000) $display("FAIL ifu_ar_addr: got %h expected 80000000", cap_ar); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL ifu_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if ({p, pa} !== 4'b1000) $display("FAIL ifu_pulse: got %b expected 1000", {p, pa}); else n_pass++;
    n_total++;
    if ({oIfuRspData, oIfuRspResp} !== {32'h0000_0413, 2'b00})
      $display("FAIL ifu_rsp: got %h/%b expected 00000413/00", oIfuRspData, oIfuRspResp);
    else n_pass++;
  endtask

  task automatic test_lsu_write_delayed();
    logic [1:0] g, ga, p, pa; int lat;
    set_cfg(0, 0, 3, 0, 0); cfg_bresp = 2'b00;
    do_txn(1'b0, 1'b1, 1'b1, '0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, g, ga, lat, p, pa);
    n_total++; if (g !== 2'b01) $display("FAIL wr_gnt: got %b expected 01", g); else n_pass++;
    n_total++; if (aw_hi !== 4) $display("FAIL wr_aw_cycles: got %0d expected 4", aw_hi); else n_pass++;
    n_total++; if (w_hi !== 1) $display("FAIL wr_w_cycles: got %0d expected 1", w_hi); else n_pass++;
    n_total++; if (b_early !== 1'b0) $display("FAIL wr_b_order: got %b expected 0", b_early); else n_pass++;
    n_total++;
    if ({cap_aw, cap_w, cap_strb} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'hF})
      $display("FAIL wr_bus: got %h %h %h expected 80001000 deadbeef f", cap_aw, cap_w, cap_strb);
    else n_pass++;
    n_total++; if (lat !== 6) $display("FAIL wr_latency: got %0d expected 6", lat); else n_pass++;
    n_total++; if ({p, pa} !== 4'b0100) $display("FAIL wr_pulse: got %b expected 0100", {p, pa}); else n_pass++;
    n_total++;
    if ({oLsuRspData, oLsuRspResp} !== {32'h0, 2'b00})
      $display("FAIL wr_rsp: got %h/%b expected 00000000/00", oLsuRspData, oLsuRspResp);
    else n_pass++;
    set_cfg(0, 0, 0, 0, 0);
  endtask

  task automatic test_conflict();
    logic [1:0] g1, g2, ga, p, pa, exp2; int lat;
`ifdef AXI_ARB_RR_EN
    exp2 = 2'b10;
`else
    exp2 = 2'b01;
`endif
    apply_reset(2);
    set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'h1111_2222; cfg_rresp = 2'b00;
    do_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, '0, '0, 1'b1, g1, ga, lat, p, pa);
    do_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, '0, '0, 1'b0, g2, ga, lat, p, pa);
    n_total++; if (g1 !== 2'b01) $display("FAIL conflict_first: got %b expected 01", g1); else n_pass++;
    n_total++; if (g2 !== exp2) $display("FAIL conflict_second: got %b expected %b", g2, exp2); else n_pass++;
    n_total++; if (p !== exp2) $display("FAIL conflict_pulse_owner: got %b expected %b", p, exp2); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL conflict_latency: got %0d expected 3", lat); else n_pass++;
  endtask

  task automatic test_error_resp();
    logic [1:0] g, ga, p, pa; int lat;
    set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b10;
    do_txn(1'b0, 1'b1, 1'b0, '0, 32'h4000_0040, '0, '0, 1'b0, g, ga, lat, p, pa);
    n_total++;
    if ({oLsuRspData, oLsuRspResp} !== {32'hCAFE_F00D, 2'b10})
      $display("FAIL err_rsp: got %h/%b expected cafef00d/10", oLsuRspData, oLsuRspResp);
    else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL err_latency: got %0d expected 3", lat); else n_pass++;
    cfg_rresp = 2'b00; cfg_rdata = 32'h5555_AAAA;
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0080, '0, '0, '0, 1'b0, g, ga, lat, p, pa);
    n_total++; if ({g, lat} !== {2'b10, 32'd3}) $display("FAIL err_then_idle: got %b/%0d expected 10/3", g, lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, ga, p, pa; int lat; bit seen; logic [4:0] bus;
    set_cfg(0, 50, 0, 0, 0);
    iIfuReq = 1'b1; iIfuAddr = 32'h0000_0F00;
    @(posedge iClock); #2; iIfuReq = 1'b0;
    @(posedge iClock); #2;
    n_total++; if (axi.r_ready !== 1'b1) $display("FAIL mid_in_rd_data: got %b expected 1", axi.r_ready); else n_pass++;
    iReset = 1'b1;
    @(posedge iClock); #2;
    bus = {axi.ar_valid, axi.r_ready, axi.aw_valid, axi.w_valid, axi.b_ready};
    n_total++; if (bus !== 5'b0) $display("FAIL mid_bus_idle: got %b expected 00000", bus); else n_pass++;
    iReset = 1'b0;
    seen = 0;
    repeat (6) begin
      if (oIfuRspValid || oLsuRspValid) seen = 1;
      @(posedge iClock); #2;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL mid_no_rsp: got %b expected 0", seen); else n_pass++;
    n_total++; if (oIfuRspData !== 32'h0) $display("FAIL mid_data_cleared: got %h expected 00000000", oIfuRspData); else n_pass++;
    set_cfg(0, 0, 0, 0, 0); cfg_rdata = 32'h0BAD_C0DE; cfg_rresp = 2'b00;
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_0F04, '0, '0, '0, 1'b0, g, ga, lat, p, pa);
    n_total++;
    if ({g, lat, oIfuRspData} !== {2'b10, 32'd3, 32'h0BAD_C0DE})
      $display("FAIL mid_recover: got %b/%0d/%h expected 10/3/0badc0de", g, lat, oIfuRspData);
    else n_pass++;
  endtask

  // Model: winner from the arbitration rule, latency as the sum of stage waits,
  // per-requester response registers held until that requester's next response.
  task automatic test_random();
    logic [1:0] g, ga, p, pa, exp_g; int lat, exp_lat, sel;
    logic ifu, lsu, we, win_lsu, is_wr;
    logic [ADDR_W-1:0] ia, la; logic [DATA_W-1:0] wd, rd; logic [MASK_W-1:0] wm;
    logic [RESP_W-1:0] rr, br;
    logic [DATA_W-1:0] m_ifu_d, m_lsu_d; logic [RESP_W-1:0] m_ifu_r, m_lsu_r;
    bit m_last_lsu;
    int a_d, r_d, aw_d, w_d, b_d;
    apply_reset(2);
    m_ifu_d = '0; m_lsu_d = '0; m_ifu_r = '0; m_lsu_r = '0; m_last_lsu = 0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(3, 1); ifu = sel[0]; lsu = sel[1]; we = $urandom_range(1, 0) != 0;
      ia = $urandom; la = $urandom; wd = $urandom; wm = 4'($urandom); rd = $urandom;
      rr = 2'($urandom); br = 2'($urandom);
      a_d = $urandom_range(3, 0); r_d = $urandom_range(3, 0);
      aw_d = $urandom_range(3, 0); w_d = $urandom_range(3, 0); b_d = $urandom_range(3, 0);
      set_cfg(a_d, r_d, aw_d, w_d, b_d); cfg_rdata = rd; cfg_rresp = rr; cfg_bresp = br;
`ifdef AXI_ARB_RR_EN
      win_lsu = lsu && (!ifu || !m_last_lsu);
`else
      win_lsu = lsu;
`endif
      m_last_lsu = win_lsu;
      is_wr = win_lsu && we;
      exp_g = {!win_lsu, win_lsu};
      exp_lat = is_wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + a_d + r_d;
      if (win_lsu) begin m_lsu_d = is_wr ? '0 : rd; m_lsu_r = is_wr ? br : rr; end
      else begin m_ifu_d = rd; m_ifu_r = rr; end
      do_txn(ifu, lsu, we, ia, la, wd, wm, 1'b0, g, ga, lat, p, pa);
      n_total++; if ({g, ga} !== {exp_g, 2'b00}) $display("FAIL rnd%0d_gnt: got %b expected %b", i, {g, ga}, {exp_g, 2'b00}); else n_pass++;
      n_total++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_lat); else n_pass++;
      n_total++; if ({p, pa} !== {exp_g, 2'b00}) $display("FAIL rnd%0d_pulse: got %b expected %b", i, {p, pa}, {exp_g, 2'b00}); else n_pass++;
      n_total++;
      if ((is_wr ? cap_aw : cap_ar) !== (win_lsu ? la : ia))
        $display("FAIL rnd%0d_addr: got %h expected %h", i, is_wr ? cap_aw : cap_ar, win_lsu ? la : ia);
      else n_pass++;
      if (is_wr) begin
        n_total++;
        if ({cap_w, cap_strb, b_early} !== {wd, wm, 1'b0})
          $display("FAIL rnd%0d_wbus: got %h/%h/%b expected %h/%h/0", i, cap_w, cap_strb, b_early, wd, wm);
        else n_pass++;
      end
      n_total++;
      if ({oIfuRspData, oIfuRspResp, oLsuRspData, oLsuRspResp} !== {m_ifu_d, m_ifu_r, m_lsu_d, m_lsu_r})
        $display("FAIL rnd%0d_rsp: got %h/%b %h/%b expected %h/%b %h/%b", i, oIfuRspData, oIfuRspResp,
                 oLsuRspData, oLsuRspResp, m_ifu_d, m_ifu_r, m_lsu_d, m_lsu_r);
      else n_pass++;
    end
  endtask

  initial begin
    iReset = 1'b1; iIfuReq = 1'b0; iLsuReq = 1'b0; iLsuWe = 1'b0;
    iIfuAddr = '0; iLsuAddr = '0; iLsuWData = '0; iLsuWMask = '0;
    test_reset();
    test_ifu_read();
    test_lsu_write_delayed();
    test_conflict();
    test_error_resp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
